// File: rtl/dds_env_pkg.sv
// Shared types and constants for the DDS ADSR envelope and VCA.
// State encodings are visible on the env_state port, so they are fixed.
package dds_env_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam logic [15:0] ENV_MAX    = 16'hFFFF;
  localparam int          MID        = 2048;
  localparam int          STEP_SHIFT = 4;

endpackage

// File: rtl/dds_vca.sv
// Two-stage VCA: centre the offset-binary sample and latch the gain,
// then scale, re-offset and clamp. Valid strobe follows the same latency.
module dds_vca
  import dds_env_pkg::*;
#(
  parameter int M     = 12,
  parameter int ENV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [M-1:0]     wave_in,
  input  logic [ENV_W-1:0] env,
  output logic [M-1:0]     wave_out,
  output logic             out_valid
);

  logic signed [M:0]    s_c, s_q;
  logic [8:0]           gain_c, gain_q;
  logic signed [M+10:0] prod, centred;
  logic [M-1:0]         clamped;
  logic                 valid_d1;

  // Full-scale envelope maps to unity gain (256) so a full-level note is lossless.
  always_comb begin
    s_c     = $signed({1'b0, wave_in}) - $signed((M+1)'(MID));
    gain_c  = (env == (ENV_W)'(ENV_MAX)) ? 9'd256 : {1'b0, env[ENV_W-1 -: 8]};
    prod    = (M+11)'(s_q) * (M+11)'($signed({1'b0, gain_q}));
    centred = (prod >>> 8) + $signed((M+11)'(MID));
    if (centred < 0)
      clamped = '0;
    else if (centred > $signed((M+11)'(2**M - 1)))
      clamped = '1;
    else
      clamped = centred[M-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      gain_q    <= '0;
      valid_d1  <= 1'b0;
      wave_out  <= (M)'(MID);
      out_valid <= 1'b0;
    end else begin
      s_q       <= s_c;
      gain_q    <= gain_c;
      valid_d1  <= sample_en;
      wave_out  <= clamped;
      out_valid <= valid_d1;
    end
  end

endmodule

// File: rtl/dds_adsr_vca.sv
// ADSR envelope generator stepped on the DDS sample strobe, driving a
// pipelined VCA that shapes the offset-binary waveform for the DAC.
module dds_adsr_vca
  import dds_env_pkg::*;
#(
  parameter int M      = 12,
  parameter int ENV_W  = 16,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              gate,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [RATE_W-1:0] sustain_level,
  input  logic [RATE_W-1:0] release_rate,
  input  logic [M-1:0]      wave_in,
  output logic [M-1:0]      wave_out,
  output logic              out_valid,
  output logic [ENV_W-1:0]  env_level,
  output logic [2:0]        env_state
);

  function automatic logic [ENV_W:0] rate_step(input logic [RATE_W-1:0] r);
    logic [ENV_W:0] t;
    t = (ENV_W+1)'(r) + (ENV_W+1)'(1);
    return t << STEP_SHIFT;
  endfunction

  env_state_t       state;
  logic [ENV_W-1:0] env;
  logic             gate_q;

  logic [ENV_W-1:0] sus, att_next, dec_next, rel_next;
  logic [ENV_W:0]   env_e, att_sum, dec_diff, rel_diff;

  // One extra bit catches overflow/underflow so every step saturates instead of wrapping.
  always_comb begin
    sus      = (ENV_W)'({sustain_level, sustain_level});
    env_e    = {1'b0, env};
    att_sum  = env_e + rate_step(attack_rate);
    dec_diff = env_e - rate_step(decay_rate);
    rel_diff = env_e - rate_step(release_rate);
    att_next = (att_sum > (ENV_W+1)'(ENV_MAX)) ? (ENV_W)'(ENV_MAX) : att_sum[ENV_W-1:0];
    dec_next = (dec_diff[ENV_W] || dec_diff[ENV_W-1:0] < sus) ? sus : dec_diff[ENV_W-1:0];
    rel_next = rel_diff[ENV_W] ? '0 : rel_diff[ENV_W-1:0];
  end

  // Retrigger keeps the current level so a re-struck note does not click.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      env    <= '0;
      gate_q <= 1'b0;
    end else if (sample_en) begin
      gate_q <= gate;
      if (gate && !gate_q) begin
        state <= ATTACK;
      end else if (!gate && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
        state <= RELEASE;
      end else begin
        case (state)
          ATTACK: begin
            env <= att_next;
            if (att_next == (ENV_W)'(ENV_MAX)) state <= DECAY;
          end
          DECAY: begin
            env <= dec_next;
            if (dec_next == sus) state <= SUSTAIN;
          end
          SUSTAIN: env <= sus;
          RELEASE: begin
            env <= rel_next;
            if (rel_next == '0) state <= IDLE;
          end
          default: begin
            env   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign env_level = env;
  assign env_state = state;

  dds_vca #(.M(M), .ENV_W(ENV_W)) u_vca (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .wave_in   (wave_in),
    .env       (env),
    .wave_out  (wave_out),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_dds_adsr_vca.sv
// Directed bench for dds_adsr_vca: envelope phases, VCA scaling,
// gate edge cases and asynchronous reset, with hand-computed expectations.
module tb_dds_adsr_vca;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic        gate;
  logic [7:0]  attack_rate, decay_rate, sustain_level, release_rate;
  logic [11:0] wave_in;
  logic [11:0] wave_out;
  logic        out_valid;
  logic [15:0] env_level;
  logic [2:0]  env_state;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  dds_adsr_vca dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_en     (sample_en),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .wave_in       (wave_in),
    .wave_out      (wave_out),
    .out_valid     (out_valid),
    .env_level     (env_level),
    .env_state     (env_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each strobe is one clk with sample_en high, driven and released on negedges.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
    end
  endtask

  task automatic checkEnv(input string tag, input logic [15:0] e, input logic [2:0] s);
    checkOutput({tag, "_env"}, 32'(env_level), 32'(e));
    checkOutput({tag, "_state"}, 32'(env_state), 32'(s));
  endtask

  task automatic vcaStrobe(input string tag, input logic [11:0] w, input logic [11:0] exp);
    @(negedge clk);
    sample_en = 1'b1;
    wave_in   = w;
    @(negedge clk);
    sample_en = 1'b0;
    checkOutput({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_wave"}, 32'(wave_out), 32'(exp));
    @(negedge clk);
    checkOutput({tag, "_valid_clear"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; gate = 1'b0; wave_in = 12'h000;
    attack_rate = 8'hFF; decay_rate = 8'hFF; sustain_level = 8'h80; release_rate = 8'h00;
    repeat (3) @(negedge clk);
    checkEnv("reset", 16'h0000, 3'd0);
    checkOutput("reset_wave", 32'(wave_out), 32'h800);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    // Attack at full rate, then decay to sustain level 0x8080.
    gate = 1'b1;
    applyStimulus(1);
    checkEnv("attack_entry", 16'h0000, 3'd1);
    applyStimulus(15);
    checkEnv("attack_15", 16'hF000, 3'd1);
    applyStimulus(1);
    checkEnv("attack_top", 16'hFFFF, 3'd2);
    vcaStrobe("vca_full", 12'hFFF, 12'hFFF);
    checkEnv("decay_1", 16'hEFFF, 3'd2);
    applyStimulus(6);
    checkEnv("decay_7", 16'h8FFF, 3'd2);
    applyStimulus(1);
    checkEnv("decay_floor", 16'h8080, 3'd3);
    vcaStrobe("vca_half_lo", 12'h000, 12'h400);
    vcaStrobe("vca_half_hi", 12'hFFF, 12'hBFF);
    checkEnv("sustain_hold", 16'h8080, 3'd3);

    // Release at the slowest rate back to IDLE.
    gate = 1'b0;
    applyStimulus(1);
    checkEnv("release_entry", 16'h8080, 3'd4);
    applyStimulus(2055);
    checkEnv("release_last", 16'h0010, 3'd4);
    applyStimulus(1);
    checkEnv("release_done", 16'h0000, 3'd0);
    vcaStrobe("vca_zero", 12'hFFF, 12'h800);

    // Gate falls mid-attack, re-rises mid-release, then a short pulse between strobes.
    gate = 1'b1;
    applyStimulus(4);
    checkEnv("attack_3000", 16'h3000, 3'd1);
    gate = 1'b0;
    release_rate = 8'hFF;
    applyStimulus(1);
    checkEnv("gate_fall", 16'h3000, 3'd4);
    applyStimulus(1);
    checkEnv("release_2000", 16'h2000, 3'd4);
    gate = 1'b1;
    applyStimulus(1);
    checkEnv("retrigger", 16'h2000, 3'd1);
    gate = 1'b0;
    applyStimulus(1);
    checkEnv("release_again", 16'h2000, 3'd4);
    @(negedge clk);
    gate = 1'b1;
    @(negedge clk);
    gate = 1'b0;
    applyStimulus(1);
    checkEnv("pulse_ignored", 16'h1000, 3'd4);
    applyStimulus(1);
    checkEnv("idle_again", 16'h0000, 3'd0);

    // Asynchronous reset in the middle of an attack with a live output.
    gate = 1'b1;
    applyStimulus(3);
    checkEnv("pre_reset", 16'h2000, 3'd1);
    @(negedge clk);
    sample_en = 1'b1;
    wave_in   = 12'h000;
    @(negedge clk);
    sample_en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_wave", 32'(wave_out), 32'h700);
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkEnv("async_reset", 16'h0000, 3'd0);
    checkOutput("async_reset_wave", 32'(wave_out), 32'h800);
    checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
